// File: rtl/step_pkg.sv
// Shared defaults and the saturating/wrapping increment used by the step counter.
package step_pkg;

    localparam int DEFAULT_THRESH = 9999;
    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_RATE_W = 8;

    // At max_val the value either holds (saturate) or rolls over to zero.
    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input logic [31:0] max_val,
                                            input logic        saturate);
        if (val >= max_val)
            return saturate ? max_val : 32'd0;
        return val + 32'd1;
    endfunction

endpackage

// File: rtl/step_channel.sv
// One pedometer channel: rising-edge detect, step count, sticky goal flag and
// per-window rate accumulator.
module step_channel
    import step_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int RATE_W   = DEFAULT_RATE_W,
    parameter int THRESH   = DEFAULT_THRESH,
    parameter int SATURATE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              count_en,
    input  logic              clear,
    input  logic              step_in,
    input  logic              window_end,
    output logic [WIDTH-1:0]  step_count,
    output logic              over_thresh,
    output logic [RATE_W-1:0] rate
);

    localparam logic [31:0] CNT_MAX  = 32'((33'd1 << WIDTH) - 33'd1);
    localparam logic [31:0] RATE_MAX = 32'((33'd1 << RATE_W) - 33'd1);
    localparam logic [31:0] THRESH_U = 32'(THRESH);

    logic              step_q;
    logic [RATE_W-1:0] acc;
    logic              qual;
    logic [WIDTH-1:0]  next_count;
    logic [RATE_W-1:0] acc_next;

    assign qual       = start & step_in & ~step_q;
    assign next_count = WIDTH'(sat_inc(32'(step_count), CNT_MAX, SATURATE != 0));
    assign acc_next   = qual ? RATE_W'(sat_inc(32'(acc), RATE_MAX, 1'b1)) : acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q      <= 1'b0;
            step_count  <= '0;
            over_thresh <= 1'b0;
            acc         <= '0;
            rate        <= '0;
        end else begin
            // Edge history tracks the input even while gated, so a level
            // held across enable/start changes never counts twice.
            step_q <= step_in;
            if (clear || !count_en) begin
                step_count  <= '0;
                over_thresh <= 1'b0;
                acc         <= '0;
                rate        <= '0;
            end else begin
                if (qual) begin
                    step_count <= next_count;
                    if (32'(next_count) >= THRESH_U)
                        over_thresh <= 1'b1;
                end
                if (window_end) begin
                    rate <= acc_next;
                    acc  <= '0;
                end else begin
                    acc  <= acc_next;
                end
            end
        end
    end

endmodule

// File: rtl/step_counter_multi.sv
// Multi-channel step counter: shared rate-window timer plus one step_channel
// per input, feeding the display mux.
module step_counter_multi
    import step_pkg::*;
#(
    parameter int N_CH       = 2,
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int SATURATE   = 1,
    parameter int THRESH     = DEFAULT_THRESH,
    parameter int WINDOW_CYC = 1000,
    parameter int RATE_W     = DEFAULT_RATE_W
) (
    input  logic                     lightClk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [N_CH-1:0]          count_en,
    input  logic [N_CH-1:0]          clear,
    input  logic [N_CH-1:0]          step_in,
    output logic [N_CH*WIDTH-1:0]    step_count,
    output logic [N_CH-1:0]          over_thresh,
    output logic [N_CH*RATE_W-1:0]   rate,
    output logic                     rate_valid
);

    localparam int            TW   = (WINDOW_CYC > 1) ? $clog2(WINDOW_CYC) : 1;
    localparam logic [TW-1:0] LAST = TW'(WINDOW_CYC - 1);

    logic [TW-1:0] timer;
    logic          window_end;

    assign window_end = start && (timer == LAST);

    // Timer freezes while start is low so a paused window resumes where it left off.
    always_ff @(posedge lightClk or posedge reset) begin
        if (reset) begin
            timer      <= '0;
            rate_valid <= 1'b0;
        end else begin
            rate_valid <= window_end;
            if (window_end)
                timer <= '0;
            else if (start)
                timer <= timer + TW'(1);
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        step_channel #(
            .WIDTH    (WIDTH),
            .RATE_W   (RATE_W),
            .THRESH   (THRESH),
            .SATURATE (SATURATE)
        ) u_ch (
            .clk         (lightClk),
            .rst         (reset),
            .start       (start),
            .count_en    (count_en[i]),
            .clear       (clear[i]),
            .step_in     (step_in[i]),
            .window_end  (window_end),
            .step_count  (step_count[i*WIDTH +: WIDTH]),
            .over_thresh (over_thresh[i]),
            .rate        (rate[i*RATE_W +: RATE_W])
        );
    end

endmodule
